sar_search_controller: RTL and testbench

//  Successive-approximation (binary) search engine: drives a trial value into an external

---
 rtl/sar_pkg.sv | 18 +
 rtl/sar_bit_mask.sv | 15 +
 rtl/sar_search_controller.sv | 127 ++++++++++++
 tb/tb_sar_search_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search engine:
// state encodings, default width and comparator flag codes.
package sar_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TEST = 2'd1,
      S_DONE = 2'd2
   } sar_state_e;

   // Comparator result packed as {greater, lesser, equal}
   localparam logic [2:0] FLAG_GT = 3'b100;
   localparam logic [2:0] FLAG_LT = 3'b010;
   localparam logic [2:0] FLAG_EQ = 3'b001;

endpackage

// File: rtl/sar_bit_mask.sv
// Bit-index to one-hot mask decoder, used to set and clear single trial bits.
module sar_bit_mask #(
   parameter int WIDTH = 4,
   parameter int IW    = 2
) (
   input  logic [IW-1:0]    idx,
   output logic [WIDTH-1:0] mask
);

   always_comb begin
      mask      = '0;
      mask[idx] = 1'b1;
   end

endmodule

// File: rtl/sar_search_controller.sv
// Binary search engine: drives a trial value into an external magnitude
// comparator and narrows it one bit per test until the unknown is recovered.
module sar_search_controller
   import sar_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             greater,
   input  logic             lesser,
   input  logic             equal,
   output logic [WIDTH-1:0] trial,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             hit,
   output logic             error,
   output logic [1:0]       state_dbg
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

   sar_state_e       state;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    idx_next;
   logic [WIDTH-1:0] cur_mask;
   logic [WIDTH-1:0] next_mask;
   logic [WIDTH-1:0] tested;
   logic [2:0]       flags;

   assign idx_next  = idx - IW'(1);
   assign flags     = {greater, lesser, equal};
   assign state_dbg = state;

   sar_bit_mask #(.WIDTH(WIDTH), .IW(IW)) u_cur_mask (
      .idx  (idx),
      .mask (cur_mask)
   );

   sar_bit_mask #(.WIDTH(WIDTH), .IW(IW)) u_next_mask (
      .idx  (idx_next),
      .mask (next_mask)
   );

   // Trial with the bit under test resolved: cleared when trial overshoots
   assign tested = greater ? (trial & ~cur_mask) : trial;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         trial  <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hit    <= 1'b0;
         error  <= 1'b0;
         idx    <= IW'(WIDTH-1);
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start && !abort) begin
                  trial <= TOP_BIT;
                  idx   <= IW'(WIDTH-1);
                  hit   <= 1'b0;
                  error <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_TEST;
               end
            end
            S_TEST: begin
               if (abort) begin
                  trial <= '0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  case (flags)
                     FLAG_EQ: begin
                        result <= trial;
                        hit    <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                     end
                     FLAG_GT, FLAG_LT: begin
                        if (idx != '0) begin
                           trial <= tested | next_mask;
                           idx   <= idx_next;
                        end else begin
                           trial  <= tested;
                           result <= tested;
                           hit    <= 1'b0;
                           busy   <= 1'b0;
                           done   <= 1'b1;
                           state  <= S_DONE;
                        end
                     end
                     default: begin
                        // zero or several flags: comparator fault
                        error  <= 1'b1;
                        result <= trial;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                     end
                  endcase
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
               if (abort) trial <= '0;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search_controller.sv
// Bench: DUT paired with a 4-bit magnitude comparator against a bench-held unknown.
module tb_sar_search_controller;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         bad = 1'b0;
   logic [W-1:0] unknown = '0;
   logic         greater, lesser, equal;
   logic [W-1:0] trial, result;
   logic         busy, done, hit, error;
   logic [1:0]   state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   // comparator; 'bad' forces an illegal code (greater and lesser together)
   assign greater = bad | (trial > unknown);
   assign lesser  = bad | (trial < unknown);
   assign equal   = !bad && (trial == unknown);

   sar_search_controller #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .greater   (greater),
      .lesser    (lesser),
      .equal     (equal),
      .trial     (trial),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .hit       (hit),
      .error     (error),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] u;
      logic [W-1:0] res;
      logic         hit;
      int           tests;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain binary search; queues every trial value it would show.
   task automatic model(input logic [W-1:0] u, output logic [W-1:0] res,
                        output logic h, output int tests);
      int acc = 0;
      h = 1'b0;
      tests = 0;
      res = '0;
      for (int b = W-1; b >= 0; b--) begin
         int t = acc + (1 << b);
         tests++;
         exp_q.push_back(W'(t));
         if (t == int'(u)) begin
            h = 1'b1;
            res = W'(t);
            return;
         end
         if (t < int'(u)) acc = t;
      end
      res = W'(acc);
   endtask

   // Drives one search; act_at values are test numbers (0 = never).
   task automatic run_search(input logic [W-1:0] u, input int bad_at, input int abort_at,
                             input int start_at, output int tests, output bit got_done);
      unknown = u;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests = 0;
      got_done = 1'b0;
      for (int cyc = 0; cyc < 3*W; cyc++) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (!busy) break;
         tests++;
         if (exp_q.size() > 0) check("trial_seq", trial, exp_q.pop_front());
         else check("trial_extra", 1, 0);
         bad   = (tests == bad_at);
         abort = (tests == abort_at);
         start = (tests == start_at);
         @(negedge clk);
         bad = 1'b0;
         abort = 1'b0;
         start = 1'b0;
      end
   endtask

   task automatic full_search(input string tag, input logic [W-1:0] u, input logic [W-1:0] eres,
                              input logic ehit, input int etests, input int start_at);
      int  tests;
      bit  got_done;
      run_search(u, 0, 0, start_at, tests, got_done);
      check({tag, "_done"}, got_done, 1);
      check({tag, "_tests"}, tests, etests);
      check({tag, "_result"}, result, eres);
      check({tag, "_hit"}, hit, ehit);
      check({tag, "_error"}, error, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_queue"}, exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_result_hold"}, result, eres);
   endtask

   initial begin
      logic [W-1:0] mres;
      logic         mhit;
      int           mtests, tests;
      bit           got_done;

      tbl[0] = '{u: 4'd5,  res: 4'd5,  hit: 1'b1, tests: 4};
      tbl[1] = '{u: 4'd0,  res: 4'd0,  hit: 1'b0, tests: 4};
      tbl[2] = '{u: 4'd8,  res: 4'd8,  hit: 1'b1, tests: 1};
      tbl[3] = '{u: 4'd12, res: 4'd12, hit: 1'b1, tests: 2};
      tbl[4] = '{u: 4'd15, res: 4'd15, hit: 1'b1, tests: 4};

      // clock / reset
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_trial", trial, 0);
      check("rst_result", result, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hit", hit, 0);
      check("rst_error", error, 0);
      check("rst_state", state_dbg, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // table vectors, trial sequence from the model
      foreach (tbl[i]) begin
         model(tbl[i].u, mres, mhit, mtests);
         full_search($sformatf("tbl%0d", i), tbl[i].u, tbl[i].res, tbl[i].hit, tbl[i].tests, 0);
      end

      // random unknowns against the model
      for (int i = 0; i < 24; i++) begin
         logic [W-1:0] u;
         u = W'($urandom_range(0, (1 << W) - 1));
         model(u, mres, mhit, mtests);
         full_search($sformatf("rnd%0d", i), u, mres, mhit, mtests, 0);
         check($sformatf("rnd%0d_recover", i), result, u);
      end

      // illegal comparator code on test 2 (unknown 5: trials 8, 4)
      exp_q.push_back(4'd8);
      exp_q.push_back(4'd4);
      run_search(4'd5, 2, 0, 0, tests, got_done);
      check("err_done", got_done, 1);
      check("err_tests", tests, 2);
      check("err_flag", error, 1);
      check("err_result", result, 4);
      check("err_hit", hit, 0);
      exp_q.delete();
      @(negedge clk);
      check("err_hold", error, 1);
      unknown = 4'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_cleared_on_start", error, 0);
      check("err_busy_after_start", busy, 1);
      repeat (6) @(negedge clk);
      check("err_clean_result", result, 3);

      // abort during test 2 (unknown 11: trials 8, 12); result keeps prior value 3
      exp_q.push_back(4'd8);
      exp_q.push_back(4'd12);
      run_search(4'd11, 0, 2, 0, tests, got_done);
      check("abort_no_done", got_done, 0);
      check("abort_tests", tests, 2);
      check("abort_trial", trial, 0);
      check("abort_result", result, 3);
      check("abort_hit", hit, 0);
      check("abort_error", error, 0);
      check("abort_state", state_dbg, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abort_idle_done", done, 0);
      end
      exp_q.delete();
      model(4'd11, mres, mhit, mtests);
      full_search("after_abort", 4'd11, 4'd11, 1'b1, 4, 0);

      // start together with abort in idle is ignored
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_state", state_dbg, 0);

      // start pulsed mid-search causes no restart
      model(4'd6, mres, mhit, mtests);
      full_search("start_in_test", 4'd6, mres, mhit, mtests, 2);

      // reset asserted mid-search clears everything at once
      unknown = 4'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_trial", trial, 0);
      check("midrst_result", result, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_hit", hit, 0);
      check("midrst_state", state_dbg, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("midrst_no_done", done, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
